// File: rtl/pipeline_assign.sv
// pipeline_assign: four-stage register-to-register ALU with a result store.
//   S1 operand fetch (regbank read, write-back forwarding)
//   S2 execute (12-function ALU)
//   S3 write-back to regbank, result register driven on Z
//   S4 store of the result into mem[addr]
// Ports:
//   clk1            system clock, rising edge
//   rst_n           asynchronous active-low reset (pipeline state only)
//   rs1, rs2        source register indices
//   rd              destination register index
//   func            ALU function code
//   addr            data-memory store address
//   Z               stage-3 result register
// regbank and mem are not reset so they can be preloaded hierarchically.
module pipeline_assign (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    input  logic [3:0]  rd,
    input  logic [3:0]  func,
    input  logic [7:0]  addr,
    output logic [15:0] Z
);

    localparam int unsigned DW   = 16;
    localparam int unsigned RW   = 4;
    localparam int unsigned FW   = 4;
    localparam int unsigned AW   = 8;
    localparam int unsigned NREG = 16;
    localparam int unsigned NMEM = 256;

    typedef enum logic [FW-1:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_MUL  = 4'd2,
        FN_SELA = 4'd3,
        FN_SELB = 4'd4,
        FN_AND  = 4'd5,
        FN_OR   = 4'd6,
        FN_XOR  = 4'd7,
        FN_NEGA = 4'd8,
        FN_NEGB = 4'd9,
        FN_SRA  = 4'd10,
        FN_SLA  = 4'd11
    } func_e;

    // Architectural storage
    logic [DW-1:0] regbank [0:NREG-1];
    logic [DW-1:0] mem     [0:NMEM-1];

    // S1 registers
    logic [DW-1:0] a1_q, a1_d;
    logic [DW-1:0] b1_q, b1_d;
    logic [RW-1:0] rd1_q;
    logic [FW-1:0] func1_q;
    logic [AW-1:0] addr1_q;
    logic          v1_q;

    // S2 registers
    logic [DW-1:0] res2_q, res2_d;
    logic [RW-1:0] rd2_q;
    logic [AW-1:0] addr2_q;
    logic          v2_q;

    // S3 registers
    logic [DW-1:0] z_q, z_d;
    logic [AW-1:0] addr3_q;
    logic          v3_q;

    logic          fwd_a_c;
    logic          fwd_b_c;

    // Operand fetch: the S2 result is written to the bank on this same edge,
    // so a matching source takes it directly instead of the stale bank entry.
    always_comb begin
        fwd_a_c = v2_q && (rd2_q == rs1);
        fwd_b_c = v2_q && (rd2_q == rs2);
        a1_d    = regbank[rs1];
        b1_d    = regbank[rs2];
        if (fwd_a_c) begin
            a1_d = res2_q;
        end
        if (fwd_b_c) begin
            b1_d = res2_q;
        end
    end

    // Execute: all arithmetic wraps modulo 2^16; unused codes give zero
    always_comb begin
        res2_d = '0;
        case (func1_q)
            FN_ADD:  res2_d = a1_q + b1_q;
            FN_SUB:  res2_d = a1_q - b1_q;
            FN_MUL:  res2_d = a1_q * b1_q;
            FN_SELA: res2_d = a1_q;
            FN_SELB: res2_d = b1_q;
            FN_AND:  res2_d = a1_q & b1_q;
            FN_OR:   res2_d = a1_q | b1_q;
            FN_XOR:  res2_d = a1_q ^ b1_q;
            FN_NEGA: res2_d = ~a1_q;
            FN_NEGB: res2_d = ~b1_q;
            FN_SRA:  res2_d = a1_q >> 1;
            FN_SLA:  res2_d = a1_q << 1;
            default: res2_d = '0;
        endcase
    end

    // Result register only follows valid instructions, so it holds 0 until the first one
    always_comb begin
        z_d = z_q;
        if (v2_q) begin
            z_d = res2_q;
        end
    end

    // Pipeline registers; reset drops every in-flight instruction
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            a1_q    <= '0;
            b1_q    <= '0;
            rd1_q   <= '0;
            func1_q <= '0;
            addr1_q <= '0;
            v1_q    <= 1'b0;
            res2_q  <= '0;
            rd2_q   <= '0;
            addr2_q <= '0;
            v2_q    <= 1'b0;
            z_q     <= '0;
            addr3_q <= '0;
            v3_q    <= 1'b0;
        end else begin
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            rd1_q   <= rd;
            func1_q <= func;
            addr1_q <= addr;
            v1_q    <= 1'b1;
            res2_q  <= res2_d;
            rd2_q   <= rd1_q;
            addr2_q <= addr1_q;
            v2_q    <= v1_q;
            z_q     <= z_d;
            addr3_q <= addr2_q;
            v3_q    <= v2_q;
        end
    end

    // Write-back and store, each gated by the valid bit of its stage
    always_ff @(posedge clk1) begin
        if (v2_q) begin
            regbank[rd2_q] <= res2_q;
        end
        if (v3_q) begin
            mem[addr3_q] <= z_q;
        end
    end

    // Store array has no read port in this block; this tap marks it as consumed.
    logic unused_mem_tap;
    assign unused_mem_tap = ^mem[addr3_q];

    assign Z = z_q;

endmodule

// File: tb/tb_pipeline_assign.sv
// Bench for pipeline_assign: directed test-plan sequences, a mid-flight reset,
// a function sweep and randomized traffic against an in-order reference model.
module tb_pipeline_assign;

    logic        clk1;
    logic        rst_n;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic [15:0] Z;

    int checks;
    int errors;

    // Reference model: architectural bank as seen by the next issue, and memory
    int unsigned arch_m [16];
    int unsigned mem_m  [256];
    int          s_rd   [0:1023];
    int          s_addr [0:1023];
    int unsigned s_res  [0:1023];
    int          n;
    bit          pend_rel;

    pipeline_assign dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd),
        .func  (func),
        .addr  (addr),
        .Z     (Z)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned alu_ref(input int unsigned f, input int unsigned a,
                                            input int unsigned b);
        case (f)
            0:  return (a + b) % 65536;
            1:  return (a + 65536 - b) % 65536;
            2:  return (a * b) % 65536;
            3:  return a;
            4:  return b;
            5:  return a & b;
            6:  return a | b;
            7:  return a ^ b;
            8:  return 65535 - a;
            9:  return 65535 - b;
            10: return a / 2;
            11: return (a * 2) % 65536;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Results become visible to a consumer two issues after their producer;
    // Z and the bank write show up two edges after issue, the store three.
    task automatic issue(input int r1, input int r2, input int rdr, input int fn, input int ad);
        int e;
        @(negedge clk1);
        if (pend_rel) begin
            rst_n    = 1'b1;
            pend_rel = 1'b0;
        end
        e = n;
        if (e >= 2) arch_m[s_rd[e-2]] = s_res[e-2];
        s_rd[e]   = rdr % 16;
        s_addr[e] = ad;
        s_res[e]  = alu_ref(fn, arch_m[r1], arch_m[r2]);
        rs1  = 4'(r1);
        rs2  = 4'(r2);
        rd   = 4'(rdr);
        func = 4'(fn);
        addr = 8'(ad);
        n++;
        @(posedge clk1);
        #1;
        chk("z_out", Z, (e >= 2) ? 16'(s_res[e-2]) : 16'h0000);
        if (e >= 2) chk("regbank_wb", dut.regbank[s_rd[e-2]], 16'(s_res[e-2]));
        if (e >= 3) begin
            mem_m[s_addr[e-3]] = s_res[e-3];
            chk("mem_store", dut.mem[s_addr[e-3]], 16'(s_res[e-3]));
        end
    endtask

    task automatic reset_now();
        #1;
        rst_n = 1'b0;
        #1;
        chk("z_async_reset", Z, 16'h0000);
        n        = 0;
        pend_rel = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        chk("z_held_reset", Z, 16'h0000);
    endtask

    logic [15:0] sweep_exp [0:11];

    initial begin
        checks   = 0;
        errors   = 0;
        n        = 0;
        pend_rel = 1'b1;
        rst_n    = 1'b0;
        rs1      = '0;
        rs2      = '0;
        rd       = '0;
        func     = '0;
        addr     = '0;
        sweep_exp[0]  = 16'h00F0;
        sweep_exp[1]  = 16'h0F0F;
        sweep_exp[2]  = 16'h0000;
        sweep_exp[3]  = 16'h0FFF;
        sweep_exp[4]  = 16'h0FFF;
        sweep_exp[5]  = 16'hFF0F;
        sweep_exp[6]  = 16'hF0F0;
        sweep_exp[7]  = 16'h0078;
        sweep_exp[8]  = 16'h01E0;
        sweep_exp[9]  = 16'h0000;
        sweep_exp[10] = 16'h0001;
        sweep_exp[11] = 16'h0000;

        // Preload storage while held in reset
        #1;
        for (int k = 0; k < 16; k++) begin
            dut.regbank[k] = 16'(k);
            arch_m[k]      = k;
        end
        for (int i = 0; i < 256; i++) begin
            dut.mem[i] = 16'(32'hC000 + i);
            mem_m[i]   = 32'hC000 + i;
        end
        repeat (2) @(posedge clk1);
        #1;
        chk("z_reset_state", Z, 16'h0000);

        // Test-plan sequence, including distance-2 forwarding and rd=16 wrap
        issue(3, 5, 10, 0, 125);
        issue(3, 8, 12, 2, 126);
        issue(10, 5, 14, 1, 128);
        issue(7, 0, 13, 11, 127);
        issue(10, 5, 15, 1, 129);
        issue(12, 13, 16, 0, 130);
        issue(0, 0, 1, 12, 250);
        issue(0, 0, 1, 12, 250);
        issue(0, 0, 1, 12, 250);
        // Three more in flight, then reset discards them
        issue(2, 2, 9, 0, 251);
        issue(2, 2, 9, 0, 252);
        issue(2, 2, 9, 0, 253);
        reset_now();

        chk("mem125_add", dut.mem[125], 16'd8);
        chk("mem126_mul", dut.mem[126], 16'd24);
        chk("mem128_fwd_sub", dut.mem[128], 16'd3);
        chk("mem127_sla", dut.mem[127], 16'd14);
        chk("mem129_sub", dut.mem[129], 16'd3);
        chk("mem130_fwd_add", dut.mem[130], 16'd38);
        chk("r10_add", dut.regbank[10], 16'd8);
        chk("r0_rd_wrap", dut.regbank[0], 16'd38);
        chk("r2_preload_kept", dut.regbank[2], 16'd2);
        chk("r9_first_inflight", dut.regbank[9], 16'd4);
        for (int i = 251; i < 254; i++) begin
            chk("mem_discarded", dut.mem[i], 16'(32'hC000 + i));
        end
        for (int k = 0; k < 16; k++) begin
            chk("regbank_after_reset", dut.regbank[k], 16'(arch_m[k]));
        end
        chk("mem250_drain", dut.mem[250], 16'(mem_m[250]));

        // Operands for the sweep and the wrap-around cases
        dut.regbank[1] = 16'h00F0; arch_m[1] = 32'h00F0;
        dut.regbank[2] = 16'h0F0F; arch_m[2] = 32'h0F0F;
        dut.regbank[3] = 16'hFFFF; arch_m[3] = 32'hFFFF;
        dut.regbank[4] = 16'h0002; arch_m[4] = 32'h0002;
        dut.regbank[5] = 16'h0100; arch_m[5] = 32'h0100;
        for (int k = 0; k < 10; k++) begin
            issue(1, 2, 6 + k, 3 + k, 200 + k);
        end
        issue(3, 4, 0, 0, 210);
        issue(5, 5, 0, 2, 211);
        for (int k = 0; k < 3; k++) begin
            issue(0, 0, 0, 12, 212);
        end
        for (int k = 0; k < 12; k++) begin
            chk("sweep_mem", dut.mem[200 + k], sweep_exp[k]);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            issue(int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(255)));
        end
        for (int k = 0; k < 3; k++) begin
            issue(0, 0, 0, 12, 0);
        end
        for (int k = 0; k < 16; k++) begin
            chk("regbank_final", dut.regbank[k], 16'(arch_m[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
